// File: rtl/mul16_err_accum.sv
`default_nettype none
// ============================================================================
// Module   : mul16_err_accum
// Brief    : Error-distance statistics for an approximate multiplier. Compares
//            approximate vs exact products over an N-sample run and keeps the
//            sample count, mismatch count, saturating error sum and max error.
// Revision : 1.0 - initial release
// ============================================================================
module mul16_err_accum #(
  parameter int P_W   = 32,
  parameter int CNT_W = 16,
  parameter int SUM_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [P_W-1:0]   approx,
  input  logic [P_W-1:0]   exact,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [SUM_W-1:0] err_sum,
  output logic [P_W-1:0]   err_max,
  output logic             sum_ovf
);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_RUN  = 2'd1;
  localparam logic [1:0] C_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_acc;
  logic             r_v1;
  logic             r_ne;
  logic [P_W-1:0]   r_d;
  logic [CNT_W-1:0] r_sample;
  logic [CNT_W-1:0] r_mis;
  logic [SUM_W-1:0] r_sum;
  logic [P_W-1:0]   r_max;
  logic             r_ovf;
  logic             w_ready;
  logic             w_busy;
  logic             w_done;
  logic             w_start_ok;
  logic             w_xfer;
  logic [P_W:0]     w_diff;
  logic [P_W-1:0]   w_abs;
  logic [SUM_W:0]   w_sum_ext;

  // start is only honoured outside RUN, and clear always wins over it
  assign w_start_ok = start && !clear && (r_state != C_RUN);
  assign w_xfer     = in_valid && w_ready;

  // Sign bit of the widened difference selects which operand order gives |a-e|
  assign w_diff    = {1'b0, approx} - {1'b0, exact};
  assign w_abs     = w_diff[P_W] ? (exact - approx) : w_diff[P_W-1:0];
  assign w_sum_ext = {1'b0, r_sum} + {{(SUM_W + 1 - P_W){1'b0}}, r_d};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= C_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; a zero-length run completes immediately
  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = C_IDLE;
    end else begin
      case (r_state)
        C_IDLE, C_DONE: if (start) w_next = (num_samples == '0) ? C_DONE : C_RUN;
        C_RUN:          if ((r_acc == r_n) && !r_v1) w_next = C_DONE;
        default:        w_next = C_IDLE;
      endcase
    end
  end

  // Output decode from state and run counters only (never from in_valid)
  always_comb begin
    w_ready = (r_state == C_RUN) && (r_acc < r_n);
    w_busy  = (r_state == C_RUN) || r_v1;
    w_done  = (r_state == C_DONE);
  end

  // Run length latch and accept counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n   <= '0;
      r_acc <= '0;
    end else if (clear) begin
      r_n   <= '0;
      r_acc <= '0;
    end else if (w_start_ok) begin
      r_n   <= num_samples;
      r_acc <= '0;
    end else if (w_xfer) begin
      r_acc <= r_acc + CNT_W'(1);
    end
  end

  // Stage 1: absolute error distance of the accepted pair
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_d  <= '0;
      r_ne <= 1'b0;
    end else if (clear) begin
      r_v1 <= 1'b0;
      r_d  <= '0;
      r_ne <= 1'b0;
    end else begin
      r_v1 <= w_xfer;
      if (w_xfer) begin
        r_d  <= w_abs;
        r_ne <= (w_abs != '0);
      end
    end
  end

  // Stage 2: fold the stage-1 result into the run statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample <= '0;
      r_mis    <= '0;
      r_sum    <= '0;
      r_max    <= '0;
      r_ovf    <= 1'b0;
    end else if (clear || w_start_ok) begin
      r_sample <= '0;
      r_mis    <= '0;
      r_sum    <= '0;
      r_max    <= '0;
      r_ovf    <= 1'b0;
    end else if (r_v1) begin
      r_sample <= r_sample + CNT_W'(1);
      r_mis    <= r_mis + {{(CNT_W - 1){1'b0}}, r_ne};
      if (r_d > r_max) r_max <= r_d;
      if (w_sum_ext[SUM_W]) begin
        r_sum <= '1;
        r_ovf <= 1'b1;
      end else begin
        r_sum <= w_sum_ext[SUM_W-1:0];
      end
    end
  end

  assign in_ready     = w_ready;
  assign busy         = w_busy;
  assign done         = w_done;
  assign sample_cnt   = r_sample;
  assign mismatch_cnt = r_mis;
  assign err_sum      = r_sum;
  assign err_max      = r_max;
  assign sum_ovf      = r_ovf;

endmodule
`default_nettype wire
